// File: rtl/alarm_pkg.sv
// Shared types and constants for the car-alarm timing path: FSM state
// encoding, interval codes understood by time_parameters, default tick rate.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_COUNT  = 2'b10,
    ST_EXPIRE = 2'b11
  } state_e;

  localparam logic [1:0] INT_ARM_DELAY = 2'b00;
  localparam logic [1:0] INT_DRIVER    = 2'b01;
  localparam logic [1:0] INT_PASSENGER = 2'b10;
  localparam logic [1:0] INT_ALARM_ON  = 2'b11;

  // Nominal 1 s count unit at 27 MHz.
  localparam int unsigned TICK_CYCLES_DEFAULT = 27_000_000;

endpackage : alarm_pkg

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES enabled
// clocks. Ports: clk, rst_n (async low), clear (sync reset of the count),
// enable (advance count), tick (high while count is at its last value).
module tick_divider
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clear wins over enable; wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule : tick_divider

// File: rtl/alarm_timer.sv
// Countdown timer for the car alarm. Requests a duration from time_parameters
// via `interval`, latches the returned `value` once, counts it down in units
// of TICK_CYCLES clocks and pulses `expired` for one cycle at zero.
// Ports: clk, rst_n (async low), start_timer, stop_timer, interval_req[1:0],
// value[3:0] (from time_parameters) -> interval[1:0], expired, busy,
// remaining[3:0]. All outputs are registers or state decodes.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_timer,
  input  logic       stop_timer,
  input  logic [1:0] interval_req,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  state_e     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic [3:0] remaining_q, remaining_d;
  logic       tick_c;
  logic       div_clear_c;

  // Divider only runs in COUNT; held at zero elsewhere so COUNT always
  // begins from a fresh count unit.
  assign div_clear_c = start_timer || (state_q != ST_COUNT);

  tick_divider #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (div_clear_c),
    .enable (state_q == ST_COUNT),
    .tick   (tick_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      interval_q  <= INT_ARM_DELAY;
      remaining_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
    end
  end

  // Next state: start beats stop beats the normal flow.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    if (start_timer) begin
      state_d    = ST_LOAD;
      interval_d = interval_req;
    end else if (stop_timer && (state_q == ST_LOAD || state_q == ST_COUNT)) begin
      state_d     = ST_IDLE;
      remaining_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          // value is sampled only here; later reprogramming is ignored.
          remaining_d = value;
          state_d     = (value == 4'd0) ? ST_EXPIRE : ST_COUNT;
        end
        ST_COUNT: begin
          if (tick_c) begin
            if (remaining_q <= 4'd1) begin
              remaining_d = 4'd0;
              state_d     = ST_EXPIRE;
            end else begin
              remaining_d = remaining_q - 4'd1;
            end
          end
        end
        ST_EXPIRE: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign interval  = interval_q;
  assign remaining = remaining_q;
  assign expired   = (state_q == ST_EXPIRE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_COUNT);

endmodule : alarm_timer

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer with TICK_CYCLES=4 and a behavioural
// time_parameters table. The reference tracks, per interval, the number of
// edges since the start edge and derives outputs from that by arithmetic.
module tb_alarm_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_timer, stop_timer;
  logic [1:0] interval_req;
  logic [3:0] value;
  logic [1:0] interval;
  logic       expired, busy;
  logic [3:0] remaining;

  logic [3:0] tp [4];   // time_parameters contents
  assign value = tp[interval];

  alarm_timer #(.TICK_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_timer  (start_timer),
    .stop_timer   (stop_timer),
    .interval_req (interval_req),
    .value        (value),
    .interval     (interval),
    .expired      (expired),
    .busy         (busy),
    .remaining    (remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // Reference: active interval, edges since its start edge, captured duration.
  bit         m_active;
  int         m_d, m_n, m_rem;
  logic [1:0] m_int;

  wire [7:0] dut_vec = {interval, expired, busy, remaining};

  function automatic logic exp_e();
    return m_active && m_d >= 1 &&
           ((m_n == 0 && m_d == 1) || (m_n > 0 && m_d == m_n * T + 1));
  endfunction

  function automatic logic exp_b();
    return m_active && (m_d == 0 || (m_n > 0 && m_d <= m_n * T));
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_int, exp_e(), exp_b(), 4'(m_rem)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_d = 0; m_n = 0; m_rem = 0; m_int = 2'b00;
  endtask

  // Drive one cycle of inputs, advance reference at the edge, settle #1.
  task automatic cyc(input logic s, input logic p, input logic [1:0] r);
    logic prev_busy;
    start_timer = s; stop_timer = p; interval_req = r;
    @(posedge clk);
    edge_cnt++;
    prev_busy = exp_b();
    if (s) begin
      m_active = 1; m_d = 0; m_int = r;
    end else if (p && prev_busy) begin
      m_active = 0; m_rem = 0;
    end else if (m_active) begin
      m_d++;
      if (m_d == 1) m_n = int'(tp[m_int]);
      if (m_n == 0) begin
        m_rem = 0;
        if (m_d > 1) m_active = 0;
      end else if (m_d <= m_n * T) begin
        m_rem = m_n - (m_d - 1) / T;
      end else begin
        m_rem = 0;
        if (m_d > m_n * T + 1) m_active = 0;
      end
    end
    #1;
    start_timer = 1'b0; stop_timer = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_timer = 0; stop_timer = 0; interval_req = 2'b00;
    tp[0] = 4'd6; tp[1] = 4'd8; tp[2] = 4'd15; tp[3] = 4'd10;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec !== 8'h00) begin
      n_err++; $display("FAIL reset_state: got %h want 00", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic test_arm_delay();
    int first = -1;
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 2'b11);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL arm_idle e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
    end
    cyc(1, 0, 2'b00);
    for (int i = 0; i < 30; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL arm_run e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (edge_cnt == 11) begin
        n_cmp++;
        if (remaining !== 4'd6) begin
          n_err++; $display("FAIL arm_load_rem: got %0d want 6", remaining);
        end
      end
      if (expired === 1'b1 && first < 0) first = edge_cnt;
      cyc(0, 0, 2'b00);
    end
    n_cmp++;
    if (first != 35) begin
      n_err++; $display("FAIL arm_expire_edge: got %0d want 35", first);
    end
  endtask

  task automatic test_zero_duration();
    int k, first = -1, busy_cnt = 0;
    tp[0] = 4'd0;
    cyc(1, 0, 2'b00);
    k = edge_cnt;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL zero_run e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (busy === 1'b1) busy_cnt++;
      if (expired === 1'b1 && first < 0) first = edge_cnt;
      cyc(0, 0, 2'b00);
    end
    n_cmp++;
    if (first != k + 1 || busy_cnt != 1) begin
      n_err++; $display("FAIL zero_expire: got edge %0d busy %0d want edge %0d busy 1", first, busy_cnt, k + 1);
    end
    tp[0] = 4'd6;
  endtask

  task automatic test_restart();
    int k2, first = -1, pulses = 0;
    cyc(1, 0, 2'b10);
    for (int i = 0; i < 41; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL restart_pass e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (expired === 1'b1) pulses++;
      cyc(0, 0, 2'b10);
    end
    cyc(1, 0, 2'b01);
    k2 = edge_cnt;
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL restart_drv e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (expired === 1'b1 && first < 0) first = edge_cnt;
      cyc(0, 0, 2'b00);
    end
    n_cmp++;
    if (pulses != 0 || first != k2 + 33) begin
      n_err++; $display("FAIL restart_expire: got pulses %0d edge %0d want 0 and %0d", pulses, first, k2 + 33);
    end
  endtask

  task automatic test_stop();
    cyc(1, 0, 2'b11);
    for (int i = 0; i < 60; i++) begin
      if (i == 10) cyc(0, 1, 2'b00);
      else if (i == 50) cyc(1, 1, 2'b11);
      else if (i == 56) cyc(0, 1, 2'b00);
      else cyc(0, 0, 2'b00);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL stop e%0d i%0d: got %h want %h", edge_cnt, i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reprogram();
    int k, first = -1;
    cyc(1, 0, 2'b01);
    k = edge_cnt;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) tp[1] = 4'd3;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL reprog e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (expired === 1'b1 && first < 0) first = edge_cnt;
      cyc(0, 0, 2'b00);
    end
    n_cmp++;
    if (first != k + 33) begin
      n_err++; $display("FAIL reprog_expire: got %0d want %0d", first, k + 33);
    end
    tp[1] = 4'd8;
  endtask

  task automatic test_back_to_back();
    int phase = 0, pulses = 0;
    bit go = 1, idle_pending = 0;
    tp[0] = 4'd1;
    for (int i = 0; i < 30; i++) begin
      cyc(go, 0, 2'b00);
      go = 0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL b2b e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
      if (expired === 1'b1) pulses++;
      if (exp_e()) begin
        phase++;
        go = (phase == 1);
        idle_pending = (phase == 2);
      end else if (idle_pending) begin
        go = 1; idle_pending = 0;
      end
    end
    n_cmp++;
    if (pulses != 3) begin
      n_err++; $display("FAIL b2b_pulses: got %0d want 3", pulses);
    end
    tp[0] = 4'd6;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) tp[$urandom_range(0, 3)] = 4'($urandom_range(0, 5));
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    tp[3] = 4'd10;
    cyc(1, 0, 2'b11);
    repeat (12) cyc(0, 0, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got %h want 00", dut_vec);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc((i == 10), 0, 2'b01);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL post_reset e%0d: got %h want %h", edge_cnt, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm_delay();
    test_zero_duration();
    test_restart();
    test_stop();
    test_reprogram();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alarm_timer
